// File: rtl/evm_poll.sv
// Clocked electronic voting machine: per-candidate vote counters, open/close
// poll sequencing and a one-candidate-per-cycle tally for winner and tie.
module evm_poll #(
  parameter int NUM_CAND = 4,
  parameter int SEL_W    = 2,
  parameter int CNT_W    = 32
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      OPEN_POLL,
  input  logic                      CLOSE_POLL,
  input  logic                      VOTE,
  input  logic [SEL_W-1:0]          S,
  output logic [NUM_CAND*CNT_W-1:0] RESULT,
  output logic [CNT_W+SEL_W-1:0]    TOTAL,
  output logic [SEL_W-1:0]          WINNER,
  output logic                      TIE,
  output logic                      VALID,
  output logic                      BUSY,
  output logic                      ACK,
  output logic                      REJECT
);

  // state    | meaning
  // IDLE     | no poll open, votes refused
  // POLL     | poll open, votes counted
  // TALLY    | scanning counters for the maximum, one candidate per cycle
  // DONE     | WINNER/TIE valid, counters readable
  typedef enum logic [1:0] {ST_IDLE, ST_POLL, ST_TALLY, ST_DONE} state_t;

  localparam int              TOT_W = CNT_W + SEL_W;
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(NUM_CAND - 1);
  localparam logic [SEL_W:0]   NUM_C = (SEL_W + 1)'(NUM_CAND);

  state_t           state, state_nxt;
  logic             vote_q;
  logic             vote_ev;
  logic             sel_ok;
  logic             sel_full;
  logic             accept;
  logic             clear_cnt;
  logic             scan_last;
  logic [CNT_W-1:0] cnt [NUM_CAND];
  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] run_max;
  logic [SEL_W-1:0] scan_idx;

  assign vote_ev   = VOTE & ~vote_q;
  assign sel_ok    = {1'b0, S} < NUM_C;
  assign accept    = vote_ev && (state == ST_POLL) && sel_ok && !sel_full;
  assign clear_cnt = OPEN_POLL && ((state == ST_IDLE) || (state == ST_DONE));
  assign scan_last = (scan_idx == LAST);

  assign BUSY  = (state == ST_TALLY);
  assign VALID = (state == ST_DONE);

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_result
    assign RESULT[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Loop-based muxes keep out-of-range selects (S >= NUM_CAND) harmless.
  always_comb begin
    sel_full = 1'b0;
    scan_cnt = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (S == SEL_W'(i)) sel_full = &cnt[i];
      if (scan_idx == SEL_W'(i)) scan_cnt = cnt[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (OPEN_POLL)  state_nxt = ST_POLL;
      ST_POLL:  if (CLOSE_POLL) state_nxt = ST_TALLY;
      ST_TALLY: if (scan_last)  state_nxt = ST_DONE;
      ST_DONE:  if (OPEN_POLL)  state_nxt = ST_POLL;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      // vote_q resets high so a VOTE held through reset is not an edge
      vote_q   <= 1'b1;
      ACK      <= 1'b0;
      REJECT   <= 1'b0;
      TOTAL    <= '0;
      scan_idx <= '0;
      run_max  <= '0;
      WINNER   <= '0;
      TIE      <= 1'b0;
      for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
    end else begin
      vote_q <= VOTE;
      ACK    <= accept;
      REJECT <= vote_ev && !accept;

      if (clear_cnt) begin
        TOTAL  <= '0;
        WINNER <= '0;
        TIE    <= 1'b0;
        for (int i = 0; i < NUM_CAND; i++) cnt[i] <= '0;
      end else if (accept) begin
        TOTAL <= TOTAL + TOT_W'(1);
        for (int i = 0; i < NUM_CAND; i++)
          if (S == SEL_W'(i)) cnt[i] <= cnt[i] + CNT_W'(1);
      end

      if ((state == ST_POLL) && CLOSE_POLL) begin
        scan_idx <= '0;
      end else if (state == ST_TALLY) begin
        if (scan_idx == '0) begin
          run_max <= scan_cnt;
          WINNER  <= '0;
          TIE     <= 1'b0;
        end else if (scan_cnt > run_max) begin
          run_max <= scan_cnt;
          WINNER  <= scan_idx;
          TIE     <= 1'b0;
        end else if (scan_cnt == run_max) begin
          TIE <= 1'b1;
        end
        if (!scan_last) scan_idx <= scan_idx + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_evm_poll.sv
// Directed bench for evm_poll: a default instance and a 3-candidate, 3-bit
// instance share stimulus; expected ACK/REJECT go through a queue.
module tb_evm_poll;

  logic         clk;
  logic         rst_n;
  logic         open_poll;
  logic         close_poll;
  logic         vote;
  logic [1:0]   s;

  logic [127:0] result_a;
  logic [33:0]  total_a;
  logic [1:0]   winner_a;
  logic         tie_a, valid_a, busy_a, ack_a, rej_a;

  logic [8:0]   result_b;
  logic [4:0]   total_b;
  logic [1:0]   winner_b;
  logic         tie_b, valid_b, busy_b, ack_b, rej_b;

  int tests;
  int fails;
  int ma [4];
  int mb [3];
  int mst;
  logic [3:0] exp_q [$];

  evm_poll u_a (
    .CLK(clk), .RESET_N(rst_n), .OPEN_POLL(open_poll), .CLOSE_POLL(close_poll),
    .VOTE(vote), .S(s), .RESULT(result_a), .TOTAL(total_a), .WINNER(winner_a),
    .TIE(tie_a), .VALID(valid_a), .BUSY(busy_a), .ACK(ack_a), .REJECT(rej_a)
  );

  evm_poll #(.NUM_CAND(3), .SEL_W(2), .CNT_W(3)) u_b (
    .CLK(clk), .RESET_N(rst_n), .OPEN_POLL(open_poll), .CLOSE_POLL(close_poll),
    .VOTE(vote), .S(s), .RESULT(result_b), .TOTAL(total_b), .WINNER(winner_b),
    .TIE(tie_b), .VALID(valid_b), .BUSY(busy_b), .ACK(ack_b), .REJECT(rej_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) ma[i] = 0;
    for (int i = 0; i < 3; i++) mb[i] = 0;
  endtask

  task automatic model_vote(input int sv);
    logic aa, ab;
    aa = (mst == 1) && (sv < 4);
    ab = (mst == 1) && (sv < 3);
    if (ab && mb[sv] >= 7) ab = 1'b0;
    if (aa) ma[sv]++;
    if (ab) mb[sv]++;
    exp_q.push_back({aa, !aa, ab, !ab});
  endtask

  task automatic check_pulse(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {ack_a, rej_a, ack_b, rej_b}, e);
    end
  endtask

  task automatic check_counts(input string tag);
    int ta, tb;
    ta = 0;
    tb = 0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_res_a"}, result_a[i*32 +: 32], ma[i]);
      ta += ma[i];
    end
    for (int i = 0; i < 3; i++) begin
      check({tag, "_res_b"}, result_b[i*3 +: 3], mb[i]);
      tb += mb[i];
    end
    check({tag, "_total_a"}, total_a, ta);
    check({tag, "_total_b"}, total_b, tb);
  endtask

  function automatic logic [2:0] win_of(input bit use_b);
    int n, m, v;
    logic [1:0] w;
    logic t;
    n = use_b ? 3 : 4;
    m = use_b ? mb[0] : ma[0];
    w = 2'd0;
    t = 1'b0;
    for (int i = 1; i < n; i++) begin
      if (use_b) v = mb[i];
      else       v = ma[i];
      if (v > m) begin
        m = v;
        w = 2'(i);
        t = 1'b0;
      end else if (v == m) begin
        t = 1'b1;
      end
    end
    return {w, t};
  endfunction

  task automatic do_vote(input int sv, input string tag);
    s = 2'(sv);
    vote = 1'b1;
    model_vote(sv);
    tick();
    check_pulse(tag);
    vote = 1'b0;
    tick();
    check({tag, "_pulse_gone"}, {ack_a, rej_a, ack_b, rej_b}, 0);
  endtask

  task automatic do_open(input string tag);
    open_poll = 1'b1;
    tick();
    open_poll = 1'b0;
    mst = 1;
    clear_model();
    check(tag, {total_a, total_b, winner_a, tie_a, valid_a, winner_b, tie_b, valid_b}, 0);
  endtask

  task automatic do_close(input bit with_open, input bit with_vote, input int sv,
                          input string tag);
    close_poll = 1'b1;
    open_poll  = with_open;
    if (with_vote) begin
      s = 2'(sv);
      vote = 1'b1;
      model_vote(sv);
    end
    tick();
    close_poll = 1'b0;
    open_poll  = 1'b0;
    vote       = 1'b0;
    if (with_vote) check_pulse({tag, "_close_vote"});
    mst = 2;
    check({tag, "_busy_k"}, {busy_a, valid_a, busy_b, valid_b}, 4'b1010);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check({tag, "_tally_seq"}, {busy_a, valid_a, busy_b, valid_b},
            {c < 4, c == 4, c < 3, c >= 3});
    end
    check({tag, "_win_a"}, {winner_a, tie_a}, win_of(1'b0));
    check({tag, "_win_b"}, {winner_b, tie_b}, win_of(1'b1));
    check_counts(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, {result_a, total_a, winner_a, tie_a, valid_a, busy_a, ack_a, rej_a}, 0);
    check({tag, "_b"}, {result_b, total_b, winner_b, tie_b, valid_b, busy_b, ack_b, rej_b}, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mst = 0;
    clear_model();
    rst_n = 1'b0;
    open_poll = 1'b0;
    close_poll = 1'b0;
    vote = 1'b1;
    s = 2'd0;

    // Reset with VOTE held high: releasing it must not create a vote edge.
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    check("vote_held_reset", {ack_a, rej_a, ack_b, rej_b}, 0);
    vote = 1'b0;
    tick();

    do_vote(0, "vote_idle");
    check_counts("idle_counts");

    do_open("open_idle");
    do_vote(0, "v0");
    do_vote(1, "v1");
    do_vote(3, "v3");
    do_vote(1, "v1b");
    do_vote(1, "v1c");
    check_counts("basic");
    do_close(1'b0, 1'b0, 0, "close_basic");

    do_vote(2, "vote_done");
    check_counts("done_counts");
    do_open("open_done");

    // Held VOTE counts once.
    s = 2'd2;
    vote = 1'b1;
    model_vote(2);
    tick();
    check_pulse("held_first");
    for (int i = 0; i < 9; i++) begin
      tick();
      check("held_no_pulse", {ack_a, rej_a, ack_b, rej_b}, 0);
    end
    vote = 1'b0;
    tick();
    check_counts("held");

    // Saturation of the 3-bit instance at 7.
    for (int i = 0; i < 9; i++) do_vote(0, "sat");
    check_counts("sat");
    do_close(1'b0, 1'b0, 0, "close_sat");

    do_open("open_tie");
    do_vote(1, "t1");
    do_vote(1, "t1b");
    do_vote(2, "t2");
    do_vote(2, "t2b");
    do_vote(0, "t0");
    do_close(1'b0, 1'b0, 0, "close_tie");

    // OPEN and CLOSE together in POLL: close wins; empty poll ties at 0.
    do_open("open_empty");
    do_close(1'b1, 1'b0, 0, "close_empty");

    do_open("open_cv");
    do_close(1'b0, 1'b1, 1, "close_vote");

    // Reset in the second TALLY cycle aborts the tally.
    do_open("open_abort");
    do_vote(0, "abort_v");
    close_poll = 1'b1;
    tick();
    close_poll = 1'b0;
    tick();
    check("abort_busy", {busy_a, busy_b}, 2'b11);
    rst_n = 1'b0;
    vote = 1'b1;
    tick();
    mst = 0;
    clear_model();
    check_all_zero("abort_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", {valid_a, busy_a, valid_b, busy_b}, 0);
    end
    do_open("open_after_abort");
    check("held_through_reset", {ack_a, rej_a, ack_b, rej_b}, 0);
    vote = 1'b0;
    tick();
    check_counts("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
